// File: rtl/muldiv_issue_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide issue controller.
// The op-code values match the encoding the multiply/divide unit decodes.
package muldiv_issue_ctrl_pkg;

    localparam logic [3:0] MT_MULTIPLY   = 4'd1;
    localparam logic [3:0] MT_MULTIPLY_U = 4'd2;
    localparam logic [3:0] MT_DIVIDE     = 4'd3;
    localparam logic [3:0] MT_DIVIDE_U   = 4'd4;
    localparam logic [3:0] MT_SET_HI     = 4'd5;
    localparam logic [3:0] MT_SET_LO     = 4'd6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2
    } state_e;

    // MTHI/MTLO complete at the launch edge; the unit never raises busy for them.
    function automatic logic is_set_op(input logic [3:0] op);
        return (op == MT_SET_HI) || (op == MT_SET_LO);
    endfunction

endpackage

// File: rtl/muldiv_watchdog.sv
// WAIT-state watchdog: counts WAIT cycles and flags a unit that stays busy too long.
// Only compiled when MULDIV_WATCHDOG_EN is defined.
`ifdef MULDIV_WATCHDOG_EN
module muldiv_watchdog #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic clk,
    input  logic reset,
    input  logic in_wait,
    input  logic busy,
    output logic timeout
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The counter holds the number of WAIT cycles already completed, so the
    // current cycle is the TIMEOUT_CYCLES-th one when it equals TIMEOUT_CYCLES-1.
    always_comb begin
        cnt_d   = in_wait ? cnt_q + 1'b1 : '0;
        timeout = in_wait && busy && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/muldiv_issue_ctrl.sv
// Initiator-side issue controller for the HI/LO multiply/divide unit.
// Optional WAIT-state watchdog is enabled by defining MULDIV_WATCHDOG_EN.
module muldiv_issue_ctrl
    import muldiv_issue_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        req_kill,
    input  logic        rd_valid,
    input  logic        rd_sel,
    output logic        md_start,
    output logic [3:0]  md_ctrl,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    input  logic        md_busy,
    input  logic [31:0] md_hi,
    input  logic [31:0] md_lo,
    output logic        stall,
    output logic [31:0] rd_data,
    output logic        rd_data_valid,
    output logic        wd_err
);

    if (TIMEOUT_CYCLES >= (1 << CNT_W)) begin : g_bad_cfg
        $error("muldiv_issue_ctrl: CNT_W too narrow for TIMEOUT_CYCLES");
    end

    state_e      state_q, state_d;
    logic [3:0]  md_ctrl_q, md_ctrl_d;
    logic [31:0] md_a_q, md_a_d;
    logic [31:0] md_b_q, md_b_d;
    logic        accept;
    logic        timeout;

`ifdef MULDIV_WATCHDOG_EN
    logic wd_err_q;
    logic wd_err_d;

    muldiv_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .in_wait (state_q == ST_WAIT),
        .busy    (md_busy),
        .timeout (timeout)
    );

    assign wd_err_d = timeout;
    assign wd_err   = wd_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_err_q <= 1'b0;
        end else begin
            wd_err_q <= wd_err_d;
        end
    end
`else
    assign timeout = 1'b0;
    assign wd_err  = 1'b0;
`endif

    assign accept = (state_q == ST_IDLE) && req_valid && !req_kill;

    // NOTE: every variable gets its hold value before the case so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        md_ctrl_d = md_ctrl_q;
        md_a_d    = md_a_q;
        md_b_d    = md_b_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    md_ctrl_d = req_op;
                    md_a_d    = req_a;
                    md_b_d    = req_b;
                    state_d   = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                state_d = is_set_op(md_ctrl_q) ? ST_IDLE : ST_WAIT;
            end
            ST_WAIT: begin
                // Busy already dropped at the edge that wrote HI/LO; unknown ops never raise it.
                if (!md_busy || timeout) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            // NOTE: the operand registers are reset too, so the unit never sees X operands or op codes.
            md_ctrl_q <= '0;
            md_a_q    <= '0;
            md_b_q    <= '0;
        end else begin
            state_q   <= state_d;
            md_ctrl_q <= md_ctrl_d;
            md_a_q    <= md_a_d;
            md_b_q    <= md_b_d;
        end
    end

    assign md_start = (state_q == ST_LAUNCH);
    assign md_ctrl  = md_ctrl_q;
    assign md_a     = md_a_q;
    assign md_b     = md_b_q;

    // A read arriving with a request is illegal; the request wins and the read is dropped.
    assign stall         = (req_valid || rd_valid) && !req_kill && (state_q != ST_IDLE);
    assign rd_data       = rd_sel ? md_hi : md_lo;
    assign rd_data_valid = rd_valid && !req_kill && !req_valid && (state_q == ST_IDLE);

endmodule

// File: doc/muldiv_issue_ctrl.md
Name: muldiv_issue_ctrl

Overview:
Initiator-side controller for the HI/LO multiply/divide unit. It sits between the MEM-stage commit point and the unit's start/ctrl/A/B/busy/HI/LO interface. It launches one operation at a time, sequences the unit's busy handshake, and serves MFHI/MFLO reads. It stalls the pipeline when a new op or a read collides with an op still in flight.

Parameters:
TIMEOUT_CYCLES, 64, WAIT-state cycles before the watchdog fires (only with the optional feature)
CNT_W, 7, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
req_valid  in  1  committed mul/div/MTHI/MTLO instruction present
req_op  in  4  op code; shared mt* encoding
req_a  in  32  rs operand
req_b  in  32  rt operand
req_kill  in  1  exception/flush this cycle; masks req_valid and rd_valid
rd_valid  in  1  MFHI/MFLO present
rd_sel  in  1  0=LO, 1=HI
md_start  out  1  start pulse to unit
md_ctrl  out  4  op to unit
md_a  out  32  operand A to unit
md_b  out  32  operand B to unit
md_busy  in  1  unit busy
md_hi  in  32  unit HI
md_lo  in  32  unit LO
stall  out  1  pipeline hold
rd_data  out  32  MFHI/MFLO result
rd_data_valid  out  1  rd_data usable this cycle
wd_err  out  1  watchdog pulse (optional feature only; tied 0 otherwise)

Behaviour:
- States: IDLE, LAUNCH, WAIT.
- Reset values: state=IDLE, md_start=0, md_ctrl=0, md_a=0, md_b=0, wd_err=0. Reset mid-operation forces IDLE. The unit shares the same reset.
- Accept: a request is accepted when state=IDLE, req_valid=1 and req_kill=0.
- On accept: at the edge, register md_ctrl/md_a/md_b from req_op/req_a/req_b and go to LAUNCH. md_start is high only in LAUNCH, for exactly one cycle.
- Accepting cycle does not stall; the pipeline moves on.
- LAUNCH -> IDLE if md_ctrl is mtSetHI or mtSetLO. The unit writes HI/LO at the LAUNCH edge and never raises busy.
- LAUNCH -> WAIT for all other ops. Busy rises at the LAUNCH edge.
- WAIT -> IDLE on the first cycle with md_busy=0. HI/LO were already updated at the same edge busy fell.
- Divide by zero: the unit leaves HI/LO untouched. The controller treats it as a normal completion.
- Unknown op code: the unit never raises busy. WAIT exits on the first cycle because md_busy=0. No error is flagged.
- stall=1 when (req_valid|rd_valid) & !req_kill & state!=IDLE; stall=0 otherwise.
- Reads: rd_data = rd_sel ? md_hi : md_lo (combinational). rd_data_valid = rd_valid & !req_kill & state=IDLE.
- Read and request in the same cycle: illegal (single-issue). The request has priority and rd_data_valid=0.
- md_a/md_b/md_ctrl hold their value outside LAUNCH, so the unit sees stable operands.
- Kill after accept does not cancel; accepted ops are committed by definition.
- Latency: MTHI/MTLO ready for a read 2 cycles after accept. Compute ops ready 1 cycle after busy falls.

Optional Feature:
MULDIV_WATCHDOG_EN
- Defined:
  - CNT_W counter clears on entering WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES with md_busy still 1: force IDLE and pulse wd_err for one cycle.
  - HI/LO contents are then unspecified.
- Undefined: no counter, WAIT lasts indefinitely, wd_err tied 0.

Decomposition:
- Shared package: mt* op-code constants (same encoding the unit decodes), state enum, is_set_op() function.
- One natural sub-module: muldiv_watchdog (counter + compare). Instantiated only under MULDIV_WATCHDOG_EN.

Test Plan:
- MULT: req_op=mtMultiply, a=0xFFFFFFFE, b=3 -> one md_start pulse. Stall on an MFLO during busy. After busy falls, MFLO reads 0xFFFFFFFA and MFHI reads 0xFFFFFFFF.
- MTHI: a=0x12345678, then MFHI on the next cycle -> stall=1 one cycle. Then rd_data=0x12345678, rd_data_valid=1.
- Back-to-back: DIVU 100/7 immediately followed by MULTU -> second request stalls until the divide completes. Final LO=0x0E, HI=0x02 from DIVU, then MULTU result overwrites.
- Kill: req_valid=1 with req_kill=1 -> no md_start, state stays IDLE, HI/LO unchanged. rd_valid with req_kill -> rd_data_valid=0.
- Reset asserted in WAIT -> next cycle state=IDLE, stall=0, md_start=0.
- Watchdog (macro defined, TIMEOUT_CYCLES=8): hold md_busy=1 forever -> wd_err pulses exactly one cycle, 8 cycles into WAIT, then IDLE.
